stack_pointer_unit: RTL and testbench

- Stack-address stage directly downstream of the stage-4 control code generator.
- Consumes the decoded stack controls for PSH/POP/CUD/CUA/CCD/CCA/RTU/RTC/LSP: LSP, DSP (the flag-qualified pass-through decrement), ISP and the WR strobe.
- Holds the architectural stack pointer and drives the stack memory address and the gated memory write.
- Tracks stack depth and traps overflow/underflow in a sticky fault state, so corrupted stack traffic never reaches memory.

---
 rtl/stack_pointer_unit.sv | 170 +++++++++++++++++
 tb/tb_stack_pointer_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_pointer_unit.sv
// Stack pointer unit: holds the architectural SP, forms the stack memory
// address and gated write strobe, tracks push depth and traps overflow /
// underflow into a sticky fault state that blocks further stack traffic.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | nothing pushed since last load/reset (depth == 0)
// ST_ACTIVE| entries on the stack, SP above the limit
// ST_FULL  | SP sits at STACK_LIMIT, next push traps
// ST_FAULT | overflow or underflow trapped; DSP/ISP ignored until cleared
module stack_pointer_unit #(
   parameter int                ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] SP_RESET    = 8'hFF,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'h80
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              LSP,
   input  logic              DSP,
   input  logic              ISP,
   input  logic              WR,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              clr_err,
   output logic [ADDR_W-1:0] sp_addr,
   output logic [ADDR_W-1:0] sp_q,
   output logic              wr_mem,
   output logic [ADDR_W-1:0] depth,
   output logic              full,
   output logic              empty,
   output logic              ovf,
   output logic              udf
);

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FULL   = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ZERO = '0;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_sp;
   logic [ADDR_W-1:0] r_depth;
   logic              r_ovf;
   logic              r_udf;

   logic [ADDR_W-1:0] w_sp_nxt;
   logic [ADDR_W-1:0] w_depth_nxt;
   logic              w_ovf_nxt;
   logic              w_udf_nxt;

   logic              w_push;
   logic              w_pop;
   logic              w_in_fault;
   logic              w_at_limit;
   logic              w_depth_zero;
   logic [ADDR_W-1:0] w_sp_dec;
   logic [ADDR_W-1:0] w_sp_inc;
   logic [ADDR_W-1:0] w_depth_inc;
   logic [ADDR_W-1:0] w_depth_dec;

   // DSP and ISP together cancel, so push/pop are the exclusive cases only.
   assign w_push       = DSP & ~ISP;
   assign w_pop        = ISP & ~DSP;
   assign w_in_fault   = (r_state == ST_FAULT);
   assign w_at_limit   = (r_sp == STACK_LIMIT);
   assign w_depth_zero = (r_depth == ZERO);
   assign w_sp_dec     = r_sp - ONE;
   assign w_sp_inc     = r_sp + ONE;
   assign w_depth_inc  = r_depth + ONE;
   assign w_depth_dec  = r_depth - ONE;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode in command priority order: load, clear, push/pop.
   always_comb begin
      w_state_nxt = r_state;
      if (LSP) begin
         w_state_nxt = ST_EMPTY;
      end else if (clr_err) begin
         if (w_depth_zero)    w_state_nxt = ST_EMPTY;
         else if (w_at_limit) w_state_nxt = ST_FULL;
         else                 w_state_nxt = ST_ACTIVE;
      end else if (!w_in_fault) begin
         if (w_push) begin
            if (w_at_limit)                   w_state_nxt = ST_FAULT;
            else if (w_sp_dec == STACK_LIMIT) w_state_nxt = ST_FULL;
            else                              w_state_nxt = ST_ACTIVE;
         end else if (w_pop) begin
            if (w_depth_zero)              w_state_nxt = ST_FAULT;
            else if (w_depth_dec == ZERO)  w_state_nxt = ST_EMPTY;
            else                           w_state_nxt = ST_ACTIVE;
         end
      end
   end

   // Datapath next values; a trapping push/pop leaves SP and depth alone.
   always_comb begin
      w_sp_nxt    = r_sp;
      w_depth_nxt = r_depth;
      w_ovf_nxt   = r_ovf;
      w_udf_nxt   = r_udf;
      if (LSP) begin
         w_sp_nxt    = data_in;
         w_depth_nxt = ZERO;
         if (clr_err) begin
            w_ovf_nxt = 1'b0;
            w_udf_nxt = 1'b0;
         end
      end else if (clr_err) begin
         w_ovf_nxt = 1'b0;
         w_udf_nxt = 1'b0;
      end else if (!w_in_fault) begin
         if (w_push) begin
            if (w_at_limit) begin
               w_ovf_nxt = 1'b1;
            end else begin
               w_sp_nxt    = w_sp_dec;
               w_depth_nxt = w_depth_inc;
            end
         end else if (w_pop) begin
            if (w_depth_zero) begin
               w_udf_nxt = 1'b1;
            end else begin
               w_sp_nxt    = w_sp_inc;
               w_depth_nxt = w_depth_dec;
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp    <= SP_RESET;
         r_depth <= ZERO;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_sp    <= w_sp_nxt;
         r_depth <= w_depth_nxt;
         r_ovf   <= w_ovf_nxt;
         r_udf   <= w_udf_nxt;
      end
   end

   // Outputs: zero-latency address and write gate, register-decoded status.
   always_comb begin
      sp_addr = r_sp;
      wr_mem  = 1'b0;
      full    = w_at_limit;
      empty   = w_depth_zero;
      if (w_push) sp_addr = w_sp_dec;
      if (WR && w_push && !w_at_limit && !w_in_fault) wr_mem = 1'b1;
   end

   assign sp_q  = r_sp;
   assign depth = r_depth;
   assign ovf   = r_ovf;
   assign udf   = r_udf;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Bench for stack_pointer_unit: directed scenarios plus a randomized run,
// all checked against a small behavioural stack model.
module tb_stack_pointer_unit;

   logic       clk = 1'b0;
   logic       rst, LSP, DSP, ISP, WR, clr_err;
   logic [7:0] data_in;
   logic [7:0] sp_addr, sp_q, depth;
   logic       wr_mem, full, empty, ovf, udf;

   int n_pass = 0;
   int n_tot  = 0;

   // model: SP, entries pushed, sticky flags, and whether traffic is blocked
   logic [7:0] m_sp    = 8'hFF;
   int         m_depth = 0;
   bit         m_ovf   = 0;
   bit         m_udf   = 0;
   bit         m_fault = 0;

   always #5 clk = ~clk;

   stack_pointer_unit dut (
      .clk(clk), .rst(rst), .LSP(LSP), .DSP(DSP), .ISP(ISP), .WR(WR),
      .data_in(data_in), .clr_err(clr_err), .sp_addr(sp_addr), .sp_q(sp_q),
      .wr_mem(wr_mem), .depth(depth), .full(full), .empty(empty),
      .ovf(ovf), .udf(udf)
   );

   task automatic drive(input bit r, input bit l, input bit d, input bit i,
                        input bit w, input bit c, input logic [7:0] din);
      rst = r; LSP = l; DSP = d; ISP = i; WR = w; clr_err = c; data_in = din;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 8'h00);
      #1;
   endtask

   // One clock edge of the abstract stack behaviour.
   task automatic model_step();
      if (rst) begin
         m_sp = 8'hFF; m_depth = 0; m_ovf = 0; m_udf = 0; m_fault = 0;
      end else if (LSP) begin
         m_sp = data_in; m_depth = 0; m_fault = 0;
         if (clr_err) begin m_ovf = 0; m_udf = 0; end
      end else if (clr_err) begin
         m_ovf = 0; m_udf = 0; m_fault = 0;
      end else if (DSP && ISP) begin
      end else if (m_fault) begin
      end else if (DSP) begin
         if (m_sp == 8'h80) begin m_ovf = 1; m_fault = 1; end
         else begin m_sp = m_sp - 8'd1; m_depth++; end
      end else if (ISP) begin
         if (m_depth == 0) begin m_udf = 1; m_fault = 1; end
         else begin m_sp = m_sp + 8'd1; m_depth--; end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 8'h00);
      tick();
      tick();
      idle();
      n_tot++; if (sp_q !== 8'hFF) $display("FAIL reset_sp_q got %h exp ff", sp_q); else n_pass++;
      n_tot++; if (sp_addr !== 8'hFF) $display("FAIL reset_sp_addr got %h exp ff", sp_addr); else n_pass++;
      n_tot++; if (depth !== 8'h00) $display("FAIL reset_depth got %h exp 00", depth); else n_pass++;
      n_tot++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else n_pass++;
      n_tot++; if (ovf !== 1'b0 || udf !== 1'b0) $display("FAIL reset_flags got ovf=%b udf=%b exp 0 0", ovf, udf); else n_pass++;
      n_tot++; if (wr_mem !== 1'b0) $display("FAIL reset_wr_mem got %b exp 0", wr_mem); else n_pass++;
   endtask

   task automatic test_push_pop();
      logic [7:0] exp_a;
      exp_a = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         exp_a = exp_a - 8'd1;
         drive(0, 0, 1, 0, 1, 0, 8'h00); #1;
         n_tot++; if (sp_addr !== exp_a || wr_mem !== 1'b1) $display("FAIL push_addr got %h/%b exp %h/1", sp_addr, wr_mem, exp_a); else n_pass++;
         tick();
      end
      idle();
      n_tot++; if (sp_q !== 8'hFC || depth !== 8'd3) $display("FAIL push3_state got sp=%h d=%0d exp fc 3", sp_q, depth); else n_pass++;
      exp_a = 8'hFC;
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1, 0, 0, 8'h00); #1;
         n_tot++; if (sp_addr !== exp_a || wr_mem !== 1'b0) $display("FAIL pop_addr got %h/%b exp %h/0", sp_addr, wr_mem, exp_a); else n_pass++;
         tick();
         exp_a = exp_a + 8'd1;
      end
      idle();
      n_tot++; if (sp_q !== 8'hFF || empty !== 1'b1) $display("FAIL pop3_state got sp=%h e=%b exp ff 1", sp_q, empty); else n_pass++;
   endtask

   task automatic test_underflow();
      drive(0, 0, 0, 1, 0, 0, 8'h00);
      tick(); idle();
      n_tot++; if (udf !== 1'b1 || sp_q !== 8'hFF) $display("FAIL udf_trap got udf=%b sp=%h exp 1 ff", udf, sp_q); else n_pass++;
      drive(0, 0, 1, 0, 1, 0, 8'h00); #1;
      n_tot++; if (wr_mem !== 1'b0) $display("FAIL fault_wr_blocked got %b exp 0", wr_mem); else n_pass++;
      tick(); idle();
      n_tot++; if (sp_q !== 8'hFF || depth !== 8'd0) $display("FAIL fault_push_ignored got sp=%h d=%0d exp ff 0", sp_q, depth); else n_pass++;
      drive(0, 0, 0, 0, 0, 1, 8'h00);
      tick(); idle();
      n_tot++; if (udf !== 1'b0 || empty !== 1'b1) $display("FAIL clr_err got udf=%b e=%b exp 0 1", udf, empty); else n_pass++;
      drive(0, 0, 1, 0, 1, 0, 8'h00); #1;
      n_tot++; if (wr_mem !== 1'b1 || sp_addr !== 8'hFE) $display("FAIL push_after_clr got %b/%h exp 1/fe", wr_mem, sp_addr); else n_pass++;
      tick(); idle();
      n_tot++; if (sp_q !== 8'hFE || depth !== 8'd1) $display("FAIL push_after_clr_state got sp=%h d=%0d exp fe 1", sp_q, depth); else n_pass++;
   endtask

   task automatic test_overflow();
      drive(0, 1, 0, 0, 0, 0, 8'h81);
      tick(); idle();
      n_tot++; if (sp_q !== 8'h81 || depth !== 8'd0) $display("FAIL lsp_load got sp=%h d=%0d exp 81 0", sp_q, depth); else n_pass++;
      drive(0, 0, 1, 0, 1, 0, 8'h00); #1;
      n_tot++; if (wr_mem !== 1'b1 || sp_addr !== 8'h80) $display("FAIL push_to_limit got %b/%h exp 1/80", wr_mem, sp_addr); else n_pass++;
      tick(); idle();
      n_tot++; if (sp_q !== 8'h80 || full !== 1'b1) $display("FAIL full_flag got sp=%h f=%b exp 80 1", sp_q, full); else n_pass++;
      drive(0, 0, 1, 0, 1, 0, 8'h00); #1;
      n_tot++; if (wr_mem !== 1'b0) $display("FAIL ovf_push_wr got %b exp 0", wr_mem); else n_pass++;
      tick(); idle();
      n_tot++; if (ovf !== 1'b1 || sp_q !== 8'h80 || depth !== 8'd1) $display("FAIL ovf_trap got ovf=%b sp=%h d=%0d exp 1 80 1", ovf, sp_q, depth); else n_pass++;
   endtask

   task automatic test_lsp_clr();
      drive(0, 1, 0, 0, 0, 1, 8'h90);
      tick(); idle();
      n_tot++; if (sp_q !== 8'h90 || depth !== 8'd0 || ovf !== 1'b0 || udf !== 1'b0 || empty !== 1'b1)
         $display("FAIL lsp_clr got sp=%h d=%0d ovf=%b udf=%b e=%b exp 90 0 0 0 1", sp_q, depth, ovf, udf, empty); else n_pass++;
      drive(0, 0, 1, 0, 1, 0, 8'h00); #1;
      n_tot++; if (wr_mem !== 1'b1 || sp_addr !== 8'h8F) $display("FAIL lsp_clr_not_fault got %b/%h exp 1/8f", wr_mem, sp_addr); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      drive(0, 0, 1, 0, 1, 0, 8'h00);
      tick();
      drive(0, 0, 1, 1, 1, 0, 8'h00); #1;
      n_tot++; if (sp_addr !== 8'h8E || wr_mem !== 1'b0) $display("FAIL dsp_isp_out got %h/%b exp 8e/0", sp_addr, wr_mem); else n_pass++;
      tick(); idle();
      n_tot++; if (sp_q !== 8'h8E || depth !== 8'd2) $display("FAIL dsp_isp_noop got sp=%h d=%0d exp 8e 2", sp_q, depth); else n_pass++;
      drive(0, 1, 0, 0, 0, 0, 8'h82); tick();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 0, 1, 0, 8'h00); tick();
      end
      idle();
      n_tot++; if (ovf !== 1'b1 || depth !== 8'd2) $display("FAIL pre_rst got ovf=%b d=%0d exp 1 2", ovf, depth); else n_pass++;
      drive(1, 0, 1, 0, 1, 0, 8'h00);
      tick(); idle();
      n_tot++; if (sp_q !== 8'hFF || depth !== 8'd0 || ovf !== 1'b0) $display("FAIL mid_rst got sp=%h d=%0d ovf=%b exp ff 0 0", sp_q, depth, ovf); else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] exp_a, din;
      bit         r, l, d, i, w, c, exp_wr, exp_full;
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(99) == 0);
         l = ($urandom_range(19) == 0);
         c = ($urandom_range(14) == 0);
         d = ($urandom_range(99) < 55);
         i = ($urandom_range(99) < 40);
         w = ($urandom_range(3) != 0);
         din = ($urandom_range(1) == 0) ? 8'(8'h80 + $urandom_range(6)) : 8'($urandom_range(255, 129));
         drive(r, l, d, i, w, c, din); #1;
         exp_a    = (d && !i) ? m_sp - 8'd1 : m_sp;
         exp_full = (m_sp == 8'h80);
         exp_wr   = w && d && !i && !exp_full && !m_fault;
         n_tot++; if (sp_addr !== exp_a) $display("FAIL rnd_sp_addr n=%0d got %h exp %h", n, sp_addr, exp_a); else n_pass++;
         n_tot++; if (wr_mem !== exp_wr) $display("FAIL rnd_wr_mem n=%0d got %b exp %b", n, wr_mem, exp_wr); else n_pass++;
         n_tot++; if (full !== exp_full) $display("FAIL rnd_full n=%0d got %b exp %b", n, full, exp_full); else n_pass++;
         tick();
         n_tot++; if (sp_q !== m_sp) $display("FAIL rnd_sp_q n=%0d got %h exp %h", n, sp_q, m_sp); else n_pass++;
         n_tot++; if (depth !== 8'(m_depth)) $display("FAIL rnd_depth n=%0d got %0d exp %0d", n, depth, m_depth); else n_pass++;
         n_tot++; if (empty !== (m_depth == 0)) $display("FAIL rnd_empty n=%0d got %b exp %b", n, empty, (m_depth == 0)); else n_pass++;
         n_tot++; if (ovf !== m_ovf || udf !== m_udf) $display("FAIL rnd_flags n=%0d got %b%b exp %b%b", n, ovf, udf, m_ovf, m_udf); else n_pass++;
      end
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 8'h00);
      @(negedge clk);
      test_reset();
      test_push_pop();
      test_underflow();
      test_overflow();
      test_lsp_clr();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
